// File: rtl/matrix_rd_stream.sv
// Streaming reader for the matrix datapath. A command names a start word and a
// word count. Words are fetched through a combinational read port and passed
// out through a small valid/ready FIFO. The issue rate follows the room left
// in the FIFO, so back-pressure from the sink never drops or repeats a word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no command; start with len!=0 latches a new command
// ISSUE | fetching words, one per cycle whenever the FIFO has room
// DRAIN | every word fetched; waiting for the sink to take the last one
module matrix_rd_stream #(
  parameter int OUT_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_L,
  input  logic        start,
  input  logic [19:0] start_addr,
  input  logic [20:0] len,
  output logic        busy,
  output logic        done,
  output logic [15:0] ram_sel,
  output logic [15:0] a,
  input  logic [31:0] mem_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam logic [PW:0] FULL_C = (PW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [19:0]   addr_q;
  logic [20:0]   cnt_q;
  logic [31:0]   fifo_data [OUT_DEPTH];
  logic          fifo_last [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          accept, issue, pop, head_last, done_q;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != '0);
  assign issue     = (state_q == ISSUE) && ((occ != FULL_C) || pop);
  assign accept    = (state_q == IDLE) && start && (len != '0);
  assign head_last = fifo_last[rd_ptr];

  // The read port is driven only in issue cycles and held at zero otherwise.
  assign ram_sel  = issue ? (16'h0001 << addr_q[19:16]) : 16'h0000;
  assign a        = issue ? addr_q[15:0] : 16'h0000;
  // The head is gated so stale FIFO contents never show after reset.
  assign out_data = out_valid ? fifo_data[rd_ptr] : 32'h0;
  assign out_last = out_valid & head_last;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // State register.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue && (cnt_q == 21'd1)) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command address and remaining count; the address wraps at the top of the matrix.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      addr_q <= start_addr;
      cnt_q  <= len;
    end else if (issue) begin
      addr_q <= addr_q + 20'd1;
      cnt_q  <= cnt_q - 21'd1;
    end
  end

  // Done pulses for a zero-length command, and after the last word has been taken.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) done_q <= 1'b0;
    else        done_q <= ((state_q == IDLE) && start && (len == '0)) ||
                          ((state_q == DRAIN) && pop && head_last);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; the read data is captured in the same cycle it is addressed.
  always_ff @(posedge CLK) begin
    if (issue) begin
      fifo_data[wr_ptr] <= mem_dout;
      fifo_last[wr_ptr] <= (cnt_q == 21'd1);
    end
  end

endmodule

// File: tb/tb_matrix_rd_stream.sv
// Bench for matrix_rd_stream. It models the matrix as a function of the
// global word address. Each accepted command queues its expected fetches and
// words, and a monitor on the falling edge checks the DUT against them.
module tb_matrix_rd_stream;

  localparam int OUT_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_L, start, out_ready;
  logic [19:0] start_addr;
  logic [20:0] len;
  logic        busy, done, out_valid, out_last;
  logic [15:0] ram_sel, a;
  logic [31:0] mem_dout, out_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int issue_cnt = 0;
  int pop_cnt = 0;

  logic [32:0] exp_q[$];   // {last, data}
  logic [31:0] iss_q[$];   // {ram_sel, a}
  bit          model_busy = 0;
  bit          exp_done = 0;
  bit          exp_first_issue = 0;
  bit          prev_stall = 0;
  logic [32:0] prev_word;

  matrix_rd_stream #(.OUT_DEPTH(OUT_DEPTH)) dut (
    .CLK(CLK), .RST_L(RST_L), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_sel(ram_sel), .a(a), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_val(input logic [19:0] g);
    if (g >= 20'h0FFFE && g <= 20'h10001) return 32'hA0 + 32'(g - 20'h0FFFE);
    return {g[11:0] ^ 12'h3C5, g};
  endfunction

  // Matrix model: combinational read of the selected RAM.
  always_comb begin
    mem_dout = 32'hBAD0_BAD0;
    for (int i = 0; i < 16; i++)
      if (ram_sel == (16'h0001 << i)) mem_dout = mem_val({i[3:0], a});
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard.
  always @(negedge CLK) begin
    if (!RST_L) begin
      chk(!busy && !done && !out_valid && !out_last && ram_sel == 0 && a == 0,
          "reset_ctrl", {busy, done, out_valid, out_last, ram_sel, a}, 0);
      chk(out_data == 0, "reset_data", out_data, 0);
      exp_q.delete();
      iss_q.delete();
      model_busy = 0; exp_done = 0; exp_first_issue = 0; prev_stall = 0;
    end else begin
      if (done || exp_done) chk(done == exp_done, "done_pulse", done, exp_done);
      if (done) done_cnt++;
      exp_done = 0;
      chk(busy == model_busy, "busy", busy, model_busy);

      if (exp_first_issue) chk(ram_sel != 0, "first_issue_latency", ram_sel, 1);
      exp_first_issue = 0;
      if (ram_sel != 0) begin
        issue_cnt++;
        if (iss_q.size() == 0) chk(0, "unexpected_issue", {ram_sel, a}, 0);
        else begin
          logic [31:0] e;
          e = iss_q.pop_front();
          chk({ram_sel, a} == e, "issue_addr", {ram_sel, a}, e);
        end
      end else if (a != 0) chk(0, "idle_a_nonzero", a, 0);

      if (prev_stall)
        chk(out_valid && {out_last, out_data} == prev_word, "stall_stable",
            {out_valid, out_last, out_data}, {1'b1, prev_word});

      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) chk(0, "unexpected_word", {out_last, out_data}, 0);
        else begin
          logic [32:0] w;
          w = exp_q.pop_front();
          chk({out_last, out_data} == w, "word", {out_last, out_data}, w);
          if (w[32]) begin
            model_busy = 0;
            exp_done = 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};

      if (start && !model_busy) begin
        if (len == 0) exp_done = 1;
        else begin
          logic [19:0] g;
          model_busy = 1;
          exp_first_issue = 1;
          g = start_addr;
          for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({(i == int'(len) - 1), mem_val(g)});
            iss_q.push_back({16'h0001 << g[19:16], g[15:0]});
            g = g + 20'd1;
          end
        end
      end
    end
  end

  task automatic do_cmd(input logic [19:0] ad, input logic [20:0] l, input bit rel);
    @(posedge CLK); #1;
    if (rel) RST_L = 1'b1;
    start = 1'b1; start_addr = ad; len = l;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output int cyc);
    int d0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge CLK); #1;
      if (rnd) out_ready = ($urandom_range(0, 1) == 1);
      cyc++;
    end
    chk(done_cnt != d0, "done_timeout", cyc, budget);
  endtask

  task automatic drained(input string name);
    chk(exp_q.size() == 0 && iss_q.size() == 0, name, exp_q.size(), 0);
  endtask

  initial begin
    int cyc, i0, p0, d1, n;
    logic [19:0] ra;
    RST_L = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
    #2 RST_L = 1'b0;
    repeat (3) @(posedge CLK);

    // Basic read across the RAM 0/1 boundary, started on the first cycle out of reset.
    do_cmd(20'h0FFFE, 21'd4, 1'b1);
    wait_done(50, 0, cyc);
    chk(cyc == 6, "basic_done_latency", cyc, 6);
    drained("basic_drained");

    // Back-pressure: only OUT_DEPTH fetches while the sink stalls.
    out_ready = 1'b0;
    i0 = issue_cnt;
    do_cmd(20'h12340, 21'd8, 1'b0);
    repeat (10) @(posedge CLK);
    #1;
    chk(issue_cnt - i0 == OUT_DEPTH, "bp_issue_count", issue_cnt - i0, OUT_DEPTH);
    chk(ram_sel == 0, "bp_ram_sel_idle", ram_sel, 0);
    out_ready = 1'b1;
    wait_done(50, 0, cyc);
    drained("bp_drained");

    // Address wrap from the last word of RAM 15 to the first word of RAM 0.
    do_cmd(20'hFFFFF, 21'd2, 1'b0);
    wait_done(20, 0, cyc);
    chk(cyc == 4, "wrap_done_latency", cyc, 4);
    drained("wrap_drained");

    // Zero-length command.
    do_cmd(20'h00010, 21'd0, 1'b0);
    wait_done(5, 0, cyc);
    chk(cyc == 1, "len0_done_latency", cyc, 1);

    // A start while busy is ignored.
    do_cmd(20'h55550, 21'd5, 1'b0);
    do_cmd(20'hAAAA0, 21'd3, 1'b0);
    wait_done(50, 0, cyc);
    d1 = done_cnt;
    repeat (10) @(posedge CLK);
    chk(done_cnt == d1, "single_done", done_cnt - d1, 0);
    drained("ignore_drained");

    // Reset partway through a command.
    p0 = pop_cnt;
    do_cmd(20'h00100, 21'd6, 1'b0);
    n = 0;
    while (pop_cnt - p0 < 3 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(pop_cnt - p0 == 3, "pops_before_reset", pop_cnt - p0, 3);
    d1 = done_cnt;
    RST_L = 1'b0;
    repeat (2) @(posedge CLK);
    do_cmd(20'h00200, 21'd2, 1'b1);
    chk(done_cnt == d1, "no_done_on_reset", done_cnt - d1, 0);
    wait_done(20, 0, cyc);
    chk(cyc == 4, "post_reset_done_latency", cyc, 4);
    drained("reset_drained");

    // Long command with a random sink.
    ra = 20'($urandom_range(0, 20'hFFFFF));
    do_cmd(ra, 21'd1000, 1'b0);
    wait_done(6000, 1, cyc);
    out_ready = 1'b1;
    drained("random_drained");

    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
